// File: rtl/flag_trap_ctrl.sv
// flag_trap_ctrl: turns rising edges of latched status flags into prioritised
// trap requests (req/ack/done). Build option: TRAP_TIMEOUT_EN adds an ack-timeout fault.
module flag_trap_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned TW          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dzf,
  input  logic        dsf,
  input  logic        dof,
  input  logic        duf,
  input  logic        dcffw,
  input  logic        dcfhl,
  input  logic        dcfhh,
  input  logic        ddf,
  input  logic        dhwf,
  input  logic        dsrf,
  input  logic        dmvf,
  input  logic        dmcf,
  input  logic        dtf,
  input  logic        mask_we,
  input  logic [5:0]  mask_in,
  input  logic        trap_ack,
  input  logic        trap_done,
  output logic        trap_req,
  output logic [2:0]  trap_cause,
  output logic [12:0] trap_snap,
  output logic [5:0]  pending,
  output logic        busy,
  output logic        timeout
);

  // state     | meaning
  // S_IDLE    | no trap outstanding; takes the highest-priority pending source
  // S_REQ     | trap_req high, waiting for trap_ack
  // S_SERVICE | control unit servicing the trap, waiting for trap_done
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  if (2 ** TW <= ACK_TIMEOUT) begin : g_tw_check
    $error("flag_trap_ctrl: TW too narrow for ACK_TIMEOUT");
  end

  state_t      state_q, state_d;
  logic [5:0]  src_w;
  logic [12:0] flags_w;
  logic [5:0]  prev_q, prev_d;
  logic [5:0]  mask_q, mask_d;
  logic [5:0]  pending_q, pending_d;
  logic [5:0]  rise_w;
  logic [5:0]  clr_vec;
  logic [2:0]  cause_q, cause_d;
  logic [2:0]  cause_sel;
  logic [12:0] snap_q, snap_d;
  logic        take_w;
  logic        done_evt;
  logic        ack_expired;

  // Source order matches mask_in / pending: {mcf,mvf,df,of,uf,tf}
  assign src_w   = {dmcf, dmvf, ddf, dof, duf, dtf};
  assign flags_w = {dtf, dmcf, dmvf, dsrf, dhwf, ddf, dcfhh, dcfhl, dcffw, duf, dof, dsf, dzf};

  assign take_w   = (state_q == S_IDLE) && (|pending_q);
  assign done_evt = (state_q == S_SERVICE) && trap_done;

  always_comb begin
    cause_sel = 3'd0;
    if (pending_q[5])      cause_sel = 3'd1;
    else if (pending_q[4]) cause_sel = 3'd2;
    else if (pending_q[3]) cause_sel = 3'd3;
    else if (pending_q[2]) cause_sel = 3'd4;
    else if (pending_q[1]) cause_sel = 3'd5;
    else if (pending_q[0]) cause_sel = 3'd6;
  end

  // Cause c maps to pending bit 6-c
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < 6; i++) begin
      if (cause_q == 3'(6 - i)) clr_vec[i] = done_evt;
    end
  end

  // A fresh edge on the bit being cleared wins over the clear
  always_comb begin
    rise_w    = src_w & ~prev_q & mask_q;
    pending_d = (pending_q & ~clr_vec) | rise_w;
    prev_d    = src_w;
    mask_d    = mask_we ? mask_in : mask_q;
    cause_d   = cause_q;
    snap_d    = snap_q;
    if (take_w) begin
      cause_d = cause_sel;
      snap_d  = flags_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= '0;
      mask_q    <= '1;
      pending_q <= '0;
      cause_q   <= '0;
      snap_q    <= '0;
    end else begin
      prev_q    <= prev_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      cause_q   <= cause_d;
      snap_q    <= snap_d;
    end
  end

`ifdef TRAP_TIMEOUT_EN
  logic [TW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // Counter idles at zero outside REQ, so it is clear on every REQ entry
  assign ack_expired = (state_q == S_REQ) && (cnt_q == TW'(ACK_TIMEOUT - 1));
  assign cnt_d       = (state_q == S_REQ) ? cnt_q + 1'b1 : '0;
  assign timeout_d   = timeout_q | (ack_expired & ~trap_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign ack_expired = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (|pending_q) state_d = S_REQ;
      S_REQ: begin
        if (trap_ack)         state_d = S_SERVICE;
        else if (ack_expired) state_d = S_IDLE;
      end
      S_SERVICE: if (trap_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    trap_req   = (state_q == S_REQ);
    busy       = (state_q != S_IDLE);
    trap_cause = (state_q != S_IDLE) ? cause_q : 3'd0;
    trap_snap  = snap_q;
    pending    = pending_q;
  end

endmodule

// File: tb/tb_flag_trap_ctrl.sv
// Bench for flag_trap_ctrl: directed scenario tasks plus a randomized run
// checked against a cause-indexed behavioural model.
module tb_flag_trap_ctrl;

  localparam int ACK_TIMEOUT = 16;
`ifdef TRAP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        dzf, dsf, dof, duf, dcffw, dcfhl, dcfhh, ddf, dhwf, dsrf, dmvf, dmcf, dtf;
  logic        mask_we;
  logic [5:0]  mask_in;
  logic        trap_ack, trap_done;
  logic        trap_req;
  logic [2:0]  trap_cause;
  logic [12:0] trap_snap;
  logic [5:0]  pending;
  logic        busy;
  logic        timeout;

  int n_chk = 0;
  int n_ok  = 0;

  flag_trap_ctrl #(.ACK_TIMEOUT(ACK_TIMEOUT), .TW(5)) dut (
    .clk(clk), .rst(rst),
    .dzf(dzf), .dsf(dsf), .dof(dof), .duf(duf), .dcffw(dcffw), .dcfhl(dcfhl),
    .dcfhh(dcfhh), .ddf(ddf), .dhwf(dhwf), .dsrf(dsrf), .dmvf(dmvf), .dmcf(dmcf), .dtf(dtf),
    .mask_we(mask_we), .mask_in(mask_in), .trap_ack(trap_ack), .trap_done(trap_done),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_snap(trap_snap),
    .pending(pending), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_flags();
    {dzf, dsf, dof, duf, dcffw, dcfhl, dcfhh, ddf, dhwf, dsrf, dmvf, dmcf, dtf} = '0;
  endtask

  task automatic ack_done();
    trap_ack = 1'b1; tick(); trap_ack = 1'b0;
    trap_done = 1'b1; tick(); trap_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_flags(); mask_we = 0; mask_in = 0; trap_ack = 0; trap_done = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_chk++; if (trap_req !== 1'b0)    $display("FAIL rst_req got=%b exp=0", trap_req); else n_ok++;
    n_chk++; if (busy !== 1'b0)        $display("FAIL rst_busy got=%b exp=0", busy); else n_ok++;
    n_chk++; if (pending !== 6'd0)     $display("FAIL rst_pending got=%b exp=000000", pending); else n_ok++;
    n_chk++; if (trap_cause !== 3'd0)  $display("FAIL rst_cause got=%0d exp=0", trap_cause); else n_ok++;
    n_chk++; if (timeout !== 1'b0)     $display("FAIL rst_timeout got=%b exp=0", timeout); else n_ok++;
    n_chk++; if (trap_snap !== 13'd0)  $display("FAIL rst_snap got=%h exp=0", trap_snap); else n_ok++;
    // all six sources rise: reset mask must let every one through
    {dmcf, dmvf, ddf, dof, duf, dtf} = 6'h3f;
    tick();
    n_chk++; if (pending !== 6'h3f)    $display("FAIL rst_mask_all got=%b exp=111111", pending); else n_ok++;
    tick();
    n_chk++; if (trap_req !== 1'b1 || trap_cause !== 3'd1)
      $display("FAIL rst_prio1 got req=%b cause=%0d exp req=1 cause=1", trap_req, trap_cause); else n_ok++;
    rst = 1'b1; clr_flags();
    tick();
    n_chk++; if (trap_req !== 1'b0 || busy !== 1'b0 || pending !== 6'd0 || trap_snap !== 13'd0)
      $display("FAIL rst_mid got req=%b busy=%b pend=%b snap=%h exp 0/0/0/0", trap_req, busy, pending, trap_snap); else n_ok++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    ddf = 1'b1;
    tick();
    n_chk++; if (pending !== 6'b001000) $display("FAIL ddf_pend got=%b exp=001000", pending); else n_ok++;
    n_chk++; if (trap_req !== 1'b0)     $display("FAIL ddf_req_early got=%b exp=0", trap_req); else n_ok++;
    tick();
    n_chk++; if (trap_req !== 1'b1 || trap_cause !== 3'd3)
      $display("FAIL ddf_req got req=%b cause=%0d exp req=1 cause=3", trap_req, trap_cause); else n_ok++;
    n_chk++; if (trap_snap !== 13'h080) $display("FAIL ddf_snap got=%h exp=080", trap_snap); else n_ok++;
    trap_done = 1'b1;
    tick();
    trap_done = 1'b0;
    n_chk++; if (trap_req !== 1'b1 || pending !== 6'b001000)
      $display("FAIL ddf_done_in_req got req=%b pend=%b exp req=1 pend=001000", trap_req, pending); else n_ok++;
    trap_ack = 1'b1;
    tick();
    n_chk++; if (trap_req !== 1'b0 || busy !== 1'b1 || trap_cause !== 3'd3)
      $display("FAIL ddf_svc got req=%b busy=%b cause=%0d exp 0/1/3", trap_req, busy, trap_cause); else n_ok++;
    tick();
    trap_ack = 1'b0;
    n_chk++; if (busy !== 1'b1 || trap_req !== 1'b0)
      $display("FAIL ddf_ack_in_svc got busy=%b req=%b exp busy=1 req=0", busy, trap_req); else n_ok++;
    trap_done = 1'b1;
    tick();
    trap_done = 1'b0;
    n_chk++; if (busy !== 1'b0 || pending !== 6'd0 || trap_cause !== 3'd0)
      $display("FAIL ddf_idle got busy=%b pend=%b cause=%0d exp 0/000000/0", busy, pending, trap_cause); else n_ok++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if (trap_req !== 1'b0 || pending !== 6'd0)
        $display("FAIL ddf_hold_retrig i=%0d got req=%b pend=%b exp 0/000000", i, trap_req, pending); else n_ok++;
    end
    ddf = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    dof = 1'b1; dmvf = 1'b1;
    tick();
    n_chk++; if (pending !== 6'b010100) $display("FAIL sim_pend got=%b exp=010100", pending); else n_ok++;
    tick();
    n_chk++; if (trap_req !== 1'b1 || trap_cause !== 3'd2)
      $display("FAIL sim_first got req=%b cause=%0d exp req=1 cause=2", trap_req, trap_cause); else n_ok++;
    n_chk++; if (trap_snap !== 13'h404) $display("FAIL sim_snap got=%h exp=404", trap_snap); else n_ok++;
    ack_done();
    n_chk++; if (pending !== 6'b000100 || busy !== 1'b0)
      $display("FAIL sim_after1 got pend=%b busy=%b exp 000100/0", pending, busy); else n_ok++;
    tick();
    n_chk++; if (trap_req !== 1'b1 || trap_cause !== 3'd4)
      $display("FAIL sim_second got req=%b cause=%0d exp req=1 cause=4", trap_req, trap_cause); else n_ok++;
    ack_done();
    clr_flags();
    tick();
    n_chk++; if (pending !== 6'd0 || busy !== 1'b0)
      $display("FAIL sim_end got pend=%b busy=%b exp 000000/0", pending, busy); else n_ok++;
  endtask

  task automatic test_mask();
    mask_we = 1'b1; mask_in = 6'b111110;
    tick();
    mask_we = 1'b0;
    dtf = 1'b1; tick();
    dtf = 1'b0; tick();
    n_chk++; if (pending !== 6'd0 || trap_req !== 1'b0)
      $display("FAIL mask_blocked got pend=%b req=%b exp 000000/0", pending, trap_req); else n_ok++;
    mask_we = 1'b1; mask_in = 6'h3f;
    tick();
    mask_we = 1'b0;
    dtf = 1'b1; tick();
    n_chk++; if (pending !== 6'b000001) $display("FAIL mask_open got=%b exp=000001", pending); else n_ok++;
    // masking a bit that is already pending must not clear it
    dtf = 1'b0; mask_we = 1'b1; mask_in = 6'b111110;
    tick();
    mask_we = 1'b0;
    n_chk++; if (trap_req !== 1'b1 || trap_cause !== 3'd6 || pending !== 6'b000001)
      $display("FAIL mask_keep got req=%b cause=%0d pend=%b exp 1/6/000001", trap_req, trap_cause, pending); else n_ok++;
    ack_done();
    mask_we = 1'b1; mask_in = 6'h3f;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic test_no_preempt();
    duf = 1'b1; tick();
    tick();
    n_chk++; if (trap_cause !== 3'd5) $display("FAIL pre_cause5 got=%0d exp=5", trap_cause); else n_ok++;
    trap_ack = 1'b1; tick(); trap_ack = 1'b0;
    dmcf = 1'b1; tick();
    n_chk++; if (busy !== 1'b1 || trap_req !== 1'b0 || trap_cause !== 3'd5 || pending !== 6'b100010)
      $display("FAIL pre_svc got busy=%b req=%b cause=%0d pend=%b exp 1/0/5/100010", busy, trap_req, trap_cause, pending); else n_ok++;
    trap_done = 1'b1; tick(); trap_done = 1'b0;
    n_chk++; if (busy !== 1'b0 || trap_cause !== 3'd0 || pending !== 6'b100000)
      $display("FAIL pre_idle got busy=%b cause=%0d pend=%b exp 0/0/100000", busy, trap_cause, pending); else n_ok++;
    tick();
    n_chk++; if (trap_req !== 1'b1 || trap_cause !== 3'd1)
      $display("FAIL pre_next got req=%b cause=%0d exp 1/1", trap_req, trap_cause); else n_ok++;
    ack_done();
    clr_flags();
    tick();
  endtask

  task automatic test_set_wins();
    dtf = 1'b1; tick();
    dtf = 1'b0; tick();
    trap_ack = 1'b1; tick(); trap_ack = 1'b0;
    tick();
    dtf = 1'b1; trap_done = 1'b1;
    tick();
    dtf = 1'b0; trap_done = 1'b0;
    n_chk++; if (pending !== 6'b000001 || busy !== 1'b0)
      $display("FAIL setwin_pend got pend=%b busy=%b exp 000001/0", pending, busy); else n_ok++;
    tick();
    n_chk++; if (trap_req !== 1'b1 || trap_cause !== 3'd6)
      $display("FAIL setwin_retrap got req=%b cause=%0d exp 1/6", trap_req, trap_cause); else n_ok++;
    ack_done();
  endtask

  task automatic test_timeout();
    dof = 1'b1; tick();
    dof = 1'b0; tick();
    n_chk++; if (trap_req !== 1'b1 || trap_cause !== 3'd4)
      $display("FAIL to_entry got req=%b cause=%0d exp 1/4", trap_req, trap_cause); else n_ok++;
`ifdef TRAP_TIMEOUT_EN
    for (int i = 1; i < ACK_TIMEOUT; i++) begin
      tick();
      n_chk++; if (trap_req !== 1'b1 || timeout !== 1'b0)
        $display("FAIL to_wait i=%0d got req=%b to=%b exp 1/0", i, trap_req, timeout); else n_ok++;
    end
    tick();
    n_chk++; if (trap_req !== 1'b0 || timeout !== 1'b1 || busy !== 1'b0 || pending !== 6'b000100)
      $display("FAIL to_fire got req=%b to=%b busy=%b pend=%b exp 0/1/0/000100", trap_req, timeout, busy, pending); else n_ok++;
    tick();
    n_chk++; if (trap_req !== 1'b1 || trap_cause !== 3'd4 || timeout !== 1'b1)
      $display("FAIL to_rereq got req=%b cause=%0d to=%b exp 1/4/1", trap_req, trap_cause, timeout); else n_ok++;
    for (int i = 1; i < ACK_TIMEOUT; i++) tick();
    trap_ack = 1'b1; tick(); trap_ack = 1'b0;
    n_chk++; if (busy !== 1'b1 || trap_req !== 1'b0)
      $display("FAIL to_ack_wins got busy=%b req=%b exp 1/0", busy, trap_req); else n_ok++;
    trap_done = 1'b1; tick(); trap_done = 1'b0;
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      n_chk++; if (trap_req !== 1'b1 || timeout !== 1'b0)
        $display("FAIL to_hold i=%0d got req=%b to=%b exp 1/0", i, trap_req, timeout); else n_ok++;
    end
    ack_done();
`endif
    n_chk++; if (busy !== 1'b0 || pending !== 6'd0)
      $display("FAIL to_end got busy=%b pend=%b exp 0/000000", busy, pending); else n_ok++;
  endtask

  task automatic test_random();
    bit          pend [1:6];
    bit          prv  [1:6];
    bit          msk  [1:6];
    bit          cur  [1:6];
    bit          rise [1:6];
    int          ph, cnt, cause, sel;
    bit          to;
    logic [12:0] snap;
    logic [5:0]  exp_pend;
    logic [2:0]  exp_cause;

    rst = 1'b1; clr_flags(); trap_ack = 0; trap_done = 0; mask_we = 0;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin pend[c] = 0; prv[c] = 0; msk[c] = 1; end
    ph = 0; cnt = 0; cause = 0; to = 0; snap = '0;

    for (int cyc = 0; cyc < 800; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) dmcf = ~dmcf;
      if ($urandom_range(0, 7) == 0) dmvf = ~dmvf;
      if ($urandom_range(0, 7) == 0) ddf  = ~ddf;
      if ($urandom_range(0, 7) == 0) dof  = ~dof;
      if ($urandom_range(0, 7) == 0) duf  = ~duf;
      if ($urandom_range(0, 7) == 0) dtf  = ~dtf;
      {dzf, dsf, dcffw, dcfhl, dcfhh, dhwf, dsrf} = 7'($urandom_range(0, 127));
      trap_ack  = ($urandom_range(0, 3) == 0);
      trap_done = ($urandom_range(0, 3) == 0);
      mask_we   = ($urandom_range(0, 29) == 0);
      mask_in   = 6'($urandom_range(0, 63));

      cur[1] = dmcf; cur[2] = dmvf; cur[3] = ddf; cur[4] = dof; cur[5] = duf; cur[6] = dtf;
      if (rst) begin
        for (int c = 1; c <= 6; c++) begin pend[c] = 0; prv[c] = 0; msk[c] = 1; end
        ph = 0; cnt = 0; cause = 0; to = 0; snap = '0;
      end else begin
        sel = 0;
        for (int c = 6; c >= 1; c--) if (pend[c]) sel = c;
        for (int c = 1; c <= 6; c++) rise[c] = cur[c] && !prv[c] && msk[c];
        for (int c = 1; c <= 6; c++)
          pend[c] = (pend[c] && !(ph == 2 && trap_done && cause == c)) || rise[c];
        case (ph)
          0: if (sel != 0) begin
               ph = 1; cause = sel; cnt = 0;
               snap = {dtf, dmcf, dmvf, dsrf, dhwf, ddf, dcfhh, dcfhl, dcffw, duf, dof, dsf, dzf};
             end
          1: if (trap_ack) ph = 2;
             else if (TO_EN) begin
               cnt++;
               if (cnt == ACK_TIMEOUT) begin ph = 0; to = 1; end
             end
          default: if (trap_done) ph = 0;
        endcase
        for (int c = 1; c <= 6; c++) prv[c] = cur[c];
        if (mask_we) for (int c = 1; c <= 6; c++) msk[c] = mask_in[6 - c];
      end

      tick();

      for (int c = 1; c <= 6; c++) exp_pend[6 - c] = pend[c];
      exp_cause = (ph == 0) ? 3'd0 : 3'(cause);
      n_chk++; if (trap_req !== (ph == 1))  $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, trap_req, (ph == 1)); else n_ok++;
      n_chk++; if (busy !== (ph != 0))      $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, (ph != 0)); else n_ok++;
      n_chk++; if (trap_cause !== exp_cause) $display("FAIL rnd_cause cyc=%0d got=%0d exp=%0d", cyc, trap_cause, exp_cause); else n_ok++;
      n_chk++; if (pending !== exp_pend)    $display("FAIL rnd_pend cyc=%0d got=%b exp=%b", cyc, pending, exp_pend); else n_ok++;
      n_chk++; if (trap_snap !== snap)      $display("FAIL rnd_snap cyc=%0d got=%h exp=%h", cyc, trap_snap, snap); else n_ok++;
      n_chk++; if (timeout !== to)          $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", cyc, timeout, to); else n_ok++;
    end
    rst = 1'b0; trap_ack = 0; trap_done = 0; mask_we = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_mask();
    test_no_preempt();
    test_set_wins();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
